// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store, data first.
// Optional: define MEM_ARB_BACK_TO_BACK_EN to hand the port straight to the other requester at completion.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_ready,
  output logic                 if_busy,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 d_busy,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, D_ACC, IF_ACC} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t               state, state_n;
  logic [3:0]           cnt, cnt_n;
  logic [WORD_SIZE-1:0] addr_q, addr_n;
  logic [WORD_SIZE-1:0] wdata_q, wdata_n;
  logic                 wr_q, wr_n;
  logic [WORD_SIZE-1:0] if_rdata_n, d_rdata_n;
  logic                 if_ready_n, d_ready_n;
  logic                 d_pend, if_pend;
  logic                 grant_d, grant_if;

  // A request whose ready pulse is showing this cycle counts as already served.
  assign d_pend  = (d_read | d_write) & ~d_ready;
  assign if_pend = if_req & ~if_ready;

  assign if_busy = if_pend;
  assign d_busy  = d_pend;

  assign mem_read  = (state != IDLE) & ~wr_q;
  assign mem_write = (state != IDLE) & wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      wr_q     <= wr_n;
      if_rdata <= if_rdata_n;
      d_rdata  <= d_rdata_n;
      if_ready <= if_ready_n;
      d_ready  <= d_ready_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    wr_n       = wr_q;
    if_rdata_n = if_rdata;
    d_rdata_n  = d_rdata;
    if_ready_n = 1'b0;
    d_ready_n  = 1'b0;
    grant_d    = 1'b0;
    grant_if   = 1'b0;

    case (state)
      IDLE: begin
        if (d_pend) begin
          grant_d = 1'b1;
        end else if (if_pend) begin
          grant_if = 1'b1;
        end
      end

      D_ACC: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n   = IDLE;
          d_ready_n = 1'b1;
          if (!wr_q) begin
            d_rdata_n = mem_rdata;
          end
`ifdef MEM_ARB_BACK_TO_BACK_EN
          grant_if = if_pend;
`endif
        end
      end

      IF_ACC: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n = IDLE;
          // A flushed fetch still finishes on the bus but is not reported.
          if (if_req) begin
            if_ready_n = 1'b1;
            if_rdata_n = mem_rdata;
          end
`ifdef MEM_ARB_BACK_TO_BACK_EN
          grant_d = d_pend;
`endif
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (grant_d) begin
      state_n = D_ACC;
      cnt_n   = CNT_LOAD;
      addr_n  = d_addr;
      wr_n    = d_write;
      if (d_write) begin
        wdata_n = d_wdata;
      end
    end else if (grant_if) begin
      state_n = IF_ACC;
      cnt_n   = CNT_LOAD;
      addr_n  = if_addr;
      wr_n    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 runs MEM_LATENCY=2 directed cases, instance 1 MEM_LATENCY=1 streaming.
// Expected cycle counts follow MEM_ARB_BACK_TO_BACK_EN when it is defined for the build.
module tb_mem_port_arbiter;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  logic [1:0]        if_req, d_read, d_write;
  logic [1:0][W-1:0] if_addr, d_addr, d_wdata;
  wire  [1:0]        if_ready, if_busy, d_ready, d_busy, mem_read, mem_write;
  wire  [1:0][W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [W-1:0] mem     [2][1024];
  logic [W-1:0] ref_mem [2][1024];

  logic [16:0] if_q0[$], if_q1[$], d_q0[$], d_q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt0 = 0;
  int wr_cnt0 = 0;
  logic [W-1:0] st_addr, st_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]),
    .if_ready(if_ready[0]), .if_busy(if_busy[0]),
    .d_read(d_read[0]), .d_write(d_write[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_ready(d_ready[0]), .d_busy(d_busy[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]),
    .if_ready(if_ready[1]), .if_busy(if_busy[1]),
    .d_read(d_read[1]), .d_write(d_write[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_ready(d_ready[1]), .d_busy(d_busy[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  assign mem_rdata[0] = mem[0][mem_addr[0][9:0]];
  assign mem_rdata[1] = mem[1][mem_addr[1][9:0]];

  always @(posedge clk) begin
    if (mem_write[0]) mem[0][mem_addr[0][9:0]] = mem_wdata[0];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pushExp(input int u, input bit is_if, input logic [16:0] e);
    if (u == 0 && is_if) if_q0.push_back(e);
    else if (u == 0)     d_q0.push_back(e);
    else if (is_if)      if_q1.push_back(e);
    else                 d_q1.push_back(e);
  endtask

  task automatic popExp(input int u, input bit is_if, output bit ok, output logic [16:0] e);
    ok = 1'b0;
    e  = '0;
    if (u == 0 && is_if) begin
      if (if_q0.size() > 0) begin ok = 1'b1; e = if_q0.pop_front(); end
    end else if (u == 0) begin
      if (d_q0.size() > 0) begin ok = 1'b1; e = d_q0.pop_front(); end
    end else if (is_if) begin
      if (if_q1.size() > 0) begin ok = 1'b1; e = if_q1.pop_front(); end
    end else begin
      if (d_q1.size() > 0) begin ok = 1'b1; e = d_q1.pop_front(); end
    end
  endtask

  // Ready pulses pop the scoreboard; a pulse with nothing outstanding is a duplicate.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin
      logic [16:0] e;
      bit          ok;
      if (!reset) begin
        if (if_ready[g]) begin
          popExp(g, 1'b1, ok, e);
          checkOutput("if_ready_expected", 32'(ok), 1);
          if (ok) checkOutput("if_rdata", if_rdata[g], e[15:0]);
        end
        if (d_ready[g]) begin
          popExp(g, 1'b0, ok, e);
          checkOutput("d_ready_expected", 32'(ok), 1);
          if (ok && !e[16]) checkOutput("d_rdata", d_rdata[g], e[15:0]);
        end
        if (mem_read[g] || mem_write[g]) checkOutput("strobe_excl", 32'(mem_read[g] & mem_write[g]), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_read[0]) rd_cnt0 <= rd_cnt0 + 1;
      if (mem_write[0]) begin
        wr_cnt0 <= wr_cnt0 + 1;
        checkOutput("st_addr", mem_addr[0], st_addr);
        checkOutput("st_wdata", mem_wdata[0], st_data);
      end
    end
  end

  task automatic applyFetch(input int u, input logic [W-1:0] addr, output int lat);
    int n;
    n = 0;
    if_addr[u] = addr;
    if_req[u]  = 1'b1;
    pushExp(u, 1'b1, {1'b0, ref_mem[u][addr[9:0]]});
    do begin
      @(negedge clk);
      n++;
    end while (!if_ready[u] && n < 60);
    checkOutput("if_wait", 32'(if_ready[u]), 1);
    checkOutput("if_busy_at_ready", 32'(if_busy[u]), 0);
    if_req[u] = 1'b0;
    lat = n;
  endtask

  task automatic applyData(input int u, input bit is_store, input logic [W-1:0] addr,
                           input logic [W-1:0] wdata, output int lat);
    int n;
    n = 0;
    d_addr[u]  = addr;
    d_wdata[u] = wdata;
    if (is_store) begin
      ref_mem[u][addr[9:0]] = wdata;
      st_addr = addr;
      st_data = wdata;
      pushExp(u, 1'b0, {1'b1, 16'h0000});
      d_write[u] = 1'b1;
    end else begin
      pushExp(u, 1'b0, {1'b0, ref_mem[u][addr[9:0]]});
      d_read[u] = 1'b1;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!d_ready[u] && n < 60);
    checkOutput("d_wait", 32'(d_ready[u]), 1);
    checkOutput("d_busy_at_ready", 32'(d_busy[u]), 0);
    d_read[u]  = 1'b0;
    d_write[u] = 1'b0;
    lat = n;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat_a, lat_b, base_rd, base_wr, c0, d_last, if_last;
    logic [6:1] rdv, ifv;

    for (int i = 0; i < 1024; i++) begin
      mem[0][i] = 16'(i) ^ 16'h5A00;
      mem[1][i] = 16'(i) ^ 16'h3C00;
    end
    mem[0][10'h010] = 16'h6A01;
    mem[0][10'h100] = 16'h1234;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[0][i] = mem[0][i];
      ref_mem[1][i] = mem[1][i];
    end

    reset   = 1'b1;
    if_req  = '0;
    d_read  = '0;
    d_write = '0;
    if_addr = '0;
    d_addr  = '0;
    d_wdata = '0;
    st_addr = '0;
    st_data = '0;
    repeat (2) @(negedge clk);

    checkOutput("rst_if_rdata", if_rdata[0], 0);
    checkOutput("rst_d_rdata", d_rdata[0], 0);
    checkOutput("rst_if_ready", 32'(if_ready[0]), 0);
    checkOutput("rst_d_ready", 32'(d_ready[0]), 0);
    checkOutput("rst_mem_read", 32'(mem_read[0]), 0);
    checkOutput("rst_mem_write", 32'(mem_write[0]), 0);
    checkOutput("rst_mem_addr", mem_addr[0], 0);
    checkOutput("rst_mem_wdata", mem_wdata[0], 0);
    checkOutput("rst_if_busy", 32'(if_busy[0]), 0);
    checkOutput("rst_d_busy", 32'(d_busy[0]), 0);
    reset = 1'b0;
    @(negedge clk);

    // Lone fetch: strobe in cycles 1..2, ready in cycle 3.
    base_rd = rd_cnt0;
    fork
      applyFetch(0, 16'h0010, lat_a);
      begin
        #1 checkOutput("t1_busy_c0", 32'(if_busy[0]), 1);
        @(negedge clk); checkOutput("t1_rd_c1", 32'(mem_read[0]), 1);
        checkOutput("t1_addr_c1", mem_addr[0], 16'h0010);
        @(negedge clk); checkOutput("t1_rd_c2", 32'(mem_read[0]), 1);
        @(negedge clk); checkOutput("t1_rd_c3", 32'(mem_read[0]), 0);
      end
    join
    checkOutput("t1_latency", lat_a, 3);
    checkOutput("t1_if_rdata", if_rdata[0], 16'h6A01);
    @(negedge clk);
    checkOutput("t1_rd_cycles", rd_cnt0 - base_rd, 2);

    // Fetch and load together: the load wins, the fetch follows.
`ifdef MEM_ARB_BACK_TO_BACK_EN
    rdv = 6'b001111;
    ifv = 6'b001100;
`else
    rdv = 6'b011011;
    ifv = 6'b011000;
`endif
    fork
      applyFetch(0, 16'h0020, lat_a);
      applyData(0, 1'b0, 16'h0100, 16'h0000, lat_b);
      begin
        for (int k = 1; k <= 6; k++) begin
          @(negedge clk);
          checkOutput($sformatf("t2_rd_c%0d", k), 32'(mem_read[0]), 32'(rdv[k]));
          if (rdv[k]) checkOutput($sformatf("t2_addr_c%0d", k), mem_addr[0], ifv[k] ? 16'h0020 : 16'h0100);
        end
      end
    join
    checkOutput("t2_d_latency", lat_b, 3);
`ifdef MEM_ARB_BACK_TO_BACK_EN
    checkOutput("t2_if_latency", lat_a, 5);
`else
    checkOutput("t2_if_latency", lat_a, 6);
`endif
    checkOutput("t2_d_rdata", d_rdata[0], 16'h1234);
    @(negedge clk);

    // Store, then read it back.
    base_rd = rd_cnt0;
    base_wr = wr_cnt0;
    applyData(0, 1'b1, 16'h0200, 16'hBEEF, lat_a);
    checkOutput("t3_latency", lat_a, 3);
    checkOutput("t3_wr_cycles", wr_cnt0 - base_wr, 2);
    checkOutput("t3_rd_cycles", rd_cnt0 - base_rd, 0);
    applyData(0, 1'b0, 16'h0200, 16'h0000, lat_a);
    checkOutput("t3_readback", d_rdata[0], 16'hBEEF);
    @(negedge clk);

    // Fetch withdrawn during its final strobe cycle.
    if_addr[0] = 16'h0030;
    if_req[0]  = 1'b1;
    @(negedge clk); checkOutput("t4_rd_c1", 32'(mem_read[0]), 1);
    @(negedge clk); checkOutput("t4_rd_c2", 32'(mem_read[0]), 1);
    if_req[0] = 1'b0;
    @(negedge clk);
    checkOutput("t4_no_ready", 32'(if_ready[0]), 0);
    checkOutput("t4_rd_c3", 32'(mem_read[0]), 0);
    checkOutput("t4_if_rdata", if_rdata[0], ref_mem[0][10'h020]);
    @(negedge clk);

    // Reset during a load abandons it; the held request restarts afterwards.
    d_addr[0] = 16'h0100;
    d_read[0] = 1'b1;
    @(negedge clk); checkOutput("t5_rd_c1", 32'(mem_read[0]), 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("t5_rst_strobe", 32'(mem_read[0]), 0);
    checkOutput("t5_rst_d_rdata", d_rdata[0], 0);
    checkOutput("t5_rst_mem_addr", mem_addr[0], 0);
    @(negedge clk);
    checkOutput("t5_no_ready", 32'(d_ready[0]), 0);
    reset     = 1'b0;
    d_read[0] = 1'b0;
    applyData(0, 1'b0, 16'h0100, 16'h0000, lat_a);
    checkOutput("t5_restart_latency", lat_a, 3);
    checkOutput("t5_restart_rdata", d_rdata[0], 16'h1234);
    @(negedge clk);

    // MEM_LATENCY=1: both sides keep re-requesting for five accesses each.
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 5; i++) applyData(1, 1'b0, 16'(16'h0040 + i), 16'h0000, lat_a);
        d_last = cyc;
      end
      begin
        for (int i = 0; i < 5; i++) applyFetch(1, 16'(16'h0080 + i), lat_b);
        if_last = cyc;
      end
    join
`ifdef MEM_ARB_BACK_TO_BACK_EN
    checkOutput("t6_d_last", d_last - c0, 14);
    checkOutput("t6_if_last", if_last - c0, 15);
`else
    checkOutput("t6_d_last", d_last - c0, 18);
    checkOutput("t6_if_last", if_last - c0, 20);
`endif
    repeat (3) @(negedge clk);

    checkOutput("sb_empty", if_q0.size() + if_q1.size() + d_q0.size() + d_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
